valid_ready_bypass_fifo: RTL and testbench
==========================================

Name: valid_ready_bypass_fifo

Overview:
- Multi-entry valid/ready FIFO with a zero-latency bypass path. It generalises the single-entry bypass buffer to DEPTH entries.
- When empty and the reader is ready, write data passes combinationally to the read side without being stored. Otherwise data is queued in order.
- Sits between a producer and a consumer on valid/ready datapaths. It absorbs backpressure bursts of up to DEPTH beats with no latency penalty on the uncongested path.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of storage entries (>=2). Any integer value is allowed; it need not be a power of two.

Ports:
- clock  input  1  clock, rising-edge.
- resetn  input  1  asynchronous active-low reset.
- write_data  input  WIDTH  write-side data.
- write_valid  input  1  write-side valid.
- write_ready  output  1  write-side ready.
- full  output  1  all DEPTH entries occupied.
- read_data  output  WIDTH  read-side data.
- read_valid  output  1  read-side valid.
- read_ready  input  1  read-side ready.
- empty  output  1  no entries occupied.
- level  output  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Storage:
  - DEPTH-entry register array, a read pointer and a write pointer, each $clog2(DEPTH) bits wide, plus an occupancy counter.
  - Pointers wrap explicitly from DEPTH-1 to 0, not by natural binary overflow.
- Reset (asynchronous, resetn=0):
  - Pointers=0, level=0.
  - Outputs: empty=1, full=0, write_ready=1, read_valid follows write_valid.
  - Array contents are not reset.
- Write handshake:
  - write_ready = !full. It is registered-state-derived only: no combinational path from read_ready to write_ready.
  - A write transfer occurs when write_valid && write_ready.
- Read side when empty (bypass):
  - read_valid = write_valid; read_data = write_data (combinational).
  - If write_valid && read_ready: the beat passes through; pointers and level are unchanged.
  - If write_valid && !read_ready: the beat is stored at the write pointer; write pointer advances; level becomes 1.
- Read side when not empty:
  - read_valid = 1; read_data = array[read pointer].
  - On read_valid && read_ready: read pointer advances.
  - A concurrent write is stored at the write pointer, never bypassed; ordering is preserved.
- Level update per cycle:
  - +1 on a stored write without a read.
  - -1 on a read from storage without a write.
  - Unchanged on simultaneous store+read, or on bypass.
- Flags:
  - empty = (level==0); full = (level==DEPTH). Both come from registered state.
- Full boundary:
  - write_ready=0 and writes are ignored, even if read_ready=1 in the same cycle.
  - Freed space is visible on the next cycle.
- Empty boundary:
  - A read draining the last entry makes empty=1 on the next cycle.
  - The bypass path becomes active from that cycle.
- Wrap-around: for any DEPTH, the sequence of stored beats is read back in write order across multiple pointer wraps.
- Reset mid-operation: all queued data is discarded immediately (asynchronously). The next cycle behaves as post-reset.
- Latency:
  - 0 cycles when empty and the reader is ready.
  - Otherwise, a beat is read out after all older beats.

Optional Feature:
- Macro: VALID_READY_BYPASS_FIFO_ALMOST_FULL_EN.
- Defined:
  - Adds parameter ALMOST_FULL_LEVEL (default DEPTH-1, range 1..DEPTH).
  - Adds output almost_full (1 bit) = (level >= ALMOST_FULL_LEVEL), registered-state-derived; reset value 0.
- Not defined: neither the parameter nor the port exists. All other behaviour is identical.

Test Plan (WIDTH=8, DEPTH=4):
1. Bypass: after reset, write_valid=1, read_ready=1, write_data=0xAA.
   -> Same cycle: read_valid=1, read_data=0xAA, empty=1, level=0.
   -> Next cycle: level still 0.
2. Fill to full: read_ready=0, write 0x01..0x04 on consecutive cycles.
   -> level steps 1,2,3,4; full=1, write_ready=0.
   -> A fifth write of 0x05 is not accepted.
3. Drain in order: from full, read_ready=1, write_valid=0.
   -> read_data 0x01,0x02,0x03,0x04 on consecutive cycles.
   -> Then empty=1, level=0, read_valid=0.
4. Steady flow with 2 entries queued: hold write_valid=1 and read_ready=1 for 100 cycles with incrementing data.
   -> level stays 2; output sequence is contiguous with no gaps or duplicates.
5. Wrap and reset: 10 cycles of mixed write/read crossing the pointer wrap, then assert resetn=0 mid-cycle with level=3.
   -> Immediately empty=1, level=0, full=0.
   -> The next bypass beat 0x5A appears unchanged.
6. Random: 50% write_valid, 50% read_ready, 1000 cycles, scoreboard.
   -> Every accepted beat is read exactly once, in order; level never exceeds 4.
   -> With the macro defined and ALMOST_FULL_LEVEL=3: almost_full=1 exactly when level>=3.

Source files
------------

// File: rtl/valid_ready_bypass_fifo.sv
// rtl/valid_ready_bypass_fifo.sv - DEPTH-entry valid/ready FIFO with zero-latency bypass when empty
// Optional almost_full output enabled by VALID_READY_BYPASS_FIFO_ALMOST_FULL_EN.
module valid_ready_bypass_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
`ifdef VALID_READY_BYPASS_FIFO_ALMOST_FULL_EN
  ,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 1
`endif
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [WIDTH-1:0]           write_data,
  input  logic                       write_valid,
  output logic                       write_ready,
  output logic                       full,
  output logic [WIDTH-1:0]           read_data,
  output logic                       read_valid,
  input  logic                       read_ready,
  output logic                       empty,
`ifdef VALID_READY_BYPASS_FIFO_ALMOST_FULL_EN
  output logic                       almost_full,
`endif
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [LW-1:0]    r_level;

  logic w_empty;
  logic w_full;
  logic w_wr_fire;
  logic w_bypass;
  logic w_store;
  logic w_pop;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == FULL_LEVEL);

  // write_ready depends on registered occupancy only, never on read_ready
  assign write_ready = !w_full;
  assign full        = w_full;
  assign empty       = w_empty;
  assign level       = r_level;

  assign read_valid = w_empty ? write_valid : 1'b1;
  assign read_data  = w_empty ? write_data : r_mem[r_rd_ptr];

  assign w_wr_fire = write_valid && !w_full;
  assign w_bypass  = w_empty && write_valid && read_ready;
  assign w_store   = w_wr_fire && !w_bypass;
  assign w_pop     = !w_empty && read_ready;

`ifdef VALID_READY_BYPASS_FIFO_ALMOST_FULL_EN
  assign almost_full = (r_level >= LW'(ALMOST_FULL_LEVEL));
`endif

  always_ff @(posedge clock) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= write_data;
    end
  end

  // Explicit wrap so non-power-of-two depths cycle through exactly DEPTH slots
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_level <= '0;
    end else begin
      case ({w_store, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: tb/tb_valid_ready_bypass_fifo.sv
// tb/tb_valid_ready_bypass_fifo.sv - scoreboard bench for valid_ready_bypass_fifo
// Set VALID_READY_BYPASS_FIFO_ALMOST_FULL_EN to also cover almost_full.
module tb_valid_ready_bypass_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH + 1);

  logic             clock;
  logic             resetn;
  logic [WIDTH-1:0] write_data;
  logic             write_valid;
  logic             write_ready;
  logic             full;
  logic [WIDTH-1:0] read_data;
  logic             read_valid;
  logic             read_ready;
  logic             empty;
  logic [LW-1:0]    level;
`ifdef VALID_READY_BYPASS_FIFO_ALMOST_FULL_EN
  logic             almost_full;
`endif

  int n_checks = 0;
  int n_pass = 0;
  bit mon_en = 0;
  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] seq_data;

`ifdef VALID_READY_BYPASS_FIFO_ALMOST_FULL_EN
  valid_ready_bypass_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL_LEVEL(3)) dut (
`else
  valid_ready_bypass_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
`endif
    .clock       (clock),
    .resetn      (resetn),
    .write_data  (write_data),
    .write_valid (write_valid),
    .write_ready (write_ready),
    .full        (full),
    .read_data   (read_data),
    .read_valid  (read_valid),
    .read_ready  (read_ready),
    .empty       (empty),
`ifdef VALID_READY_BYPASS_FIFO_ALMOST_FULL_EN
    .almost_full (almost_full),
`endif
    .level       (level)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: queue size is the expected occupancy before this edge
  always @(negedge clock) begin : monitor
    int sz;
    bit acc;
    if (resetn && mon_en) begin
      sz = sb.size();
      acc = write_valid && (sz < DEPTH);
      check_eq("level", 32'(level), 32'(sz));
      check_eq("empty", 32'(empty), 32'(sz == 0));
      check_eq("full", 32'(full), 32'(sz == DEPTH));
      check_eq("write_ready", 32'(write_ready), 32'(sz != DEPTH));
      check_eq("read_valid", 32'(read_valid), (sz == 0) ? 32'(write_valid) : 32'd1);
`ifdef VALID_READY_BYPASS_FIFO_ALMOST_FULL_EN
      check_eq("almost_full", 32'(almost_full), 32'(sz >= 3));
`endif
      if (sz == 0) begin
        if (write_valid) check_eq("bypass_data", 32'(read_data), 32'(write_data));
        if (acc && !read_ready) sb.push_back(write_data);
      end else begin
        if (read_ready) begin
          check_eq("read_data", 32'(read_data), 32'(sb[0]));
          void'(sb.pop_front());
        end
        if (acc) sb.push_back(write_data);
      end
    end
  end

  task automatic drive(input bit wv, input logic [WIDTH-1:0] wd, input bit rr);
    @(posedge clock);
    #1;
    write_valid = wv;
    write_data  = wd;
    read_ready  = rr;
  endtask

  initial begin
    resetn = 0;
    write_valid = 0;
    write_data = '0;
    read_ready = 0;
    seq_data = '0;
    #2;
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_write_ready", 32'(write_ready), 32'd1);
    check_eq("rst_read_valid", 32'(read_valid), 32'd0);
    @(posedge clock);
    #1;
    resetn = 1;
    mon_en = 1;

    // 1. bypass
    drive(1, 8'hAA, 1);
    #1;
    check_eq("t1_read_valid", 32'(read_valid), 32'd1);
    check_eq("t1_read_data", 32'(read_data), 32'hAA);
    drive(0, 8'h00, 1);

    // 2. fill to full, fifth write refused
    for (int i = 1; i <= 5; i++) drive(1, 8'(i), 0);
    drive(0, 8'h00, 0);
    #1;
    check_eq("t2_full", 32'(full), 32'd1);
    check_eq("t2_level", 32'(level), 32'd4);

    // 3. drain in order
    for (int i = 0; i < 5; i++) drive(0, 8'h00, 1);
    #1;
    check_eq("t3_empty", 32'(empty), 32'd1);
    check_eq("t3_read_valid", 32'(read_valid), 32'd0);

    // 4. steady flow with two entries queued
    for (int i = 0; i < 2; i++) begin
      drive(1, seq_data, 0);
      seq_data++;
    end
    for (int i = 0; i < 100; i++) begin
      drive(1, seq_data, 1);
      seq_data++;
    end
    drive(0, 8'h00, 0);
    #1;
    check_eq("t4_level", 32'(level), 32'd2);

    // 5. mixed traffic across the wrap, then asynchronous reset at level 3
    for (int i = 0; i < 10; i++) begin
      drive(1, seq_data, (i % 2) == 1);
      seq_data++;
    end
    drive(0, 8'h00, 0);
    @(posedge clock);
    #3;
    check_eq("t5_pre_level", 32'(level), 32'd3);
    resetn = 0;
    sb.delete();
    #1;
    check_eq("t5_empty", 32'(empty), 32'd1);
    check_eq("t5_level", 32'(level), 32'd0);
    check_eq("t5_full", 32'(full), 32'd0);
    @(posedge clock);
    #1;
    resetn = 1;
    write_valid = 1;
    write_data = 8'h5A;
    read_ready = 1;
    #1;
    check_eq("t5_bypass", 32'(read_data), 32'h5A);
    check_eq("t5_bypass_valid", 32'(read_valid), 32'd1);

    // 6. random traffic
    for (int i = 0; i < 1000; i++) begin
      drive($urandom_range(1), 8'($urandom), $urandom_range(1));
    end
    for (int i = 0; i < DEPTH + 2; i++) drive(0, 8'h00, 1);
    @(negedge clock);
    #1;
    check_eq("t6_sb_empty", 32'(sb.size()), 32'd0);
    mon_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
